sha_block_fifo: RTL and testbench
=================================

Name: sha_block_fifo

Overview:
- Parametrised multi-entry buffer for SHA message blocks. Generalises the single-register 448-bit block store to DEPTH entries of configurable width.
- Uses a valid/ready handshake on both sides, first-word-fall-through output, occupancy count and a synchronous flush.
- Sits between the block/nonce generator and the SHA-256 core. Lets the producer run ahead while the core is busy compressing a block.

Parameters:
- BLOCK_W, 448: width of one stored block in bits (512 for full message blocks).
- DEPTH, 4: number of entries; any integer >= 2, not restricted to powers of two.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count (derived; do not override).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries; has priority over push/pop.
- in_valid  in  1  producer presents block_in.
- in_ready  out  1  buffer can accept a block this cycle.
- block_in  in  BLOCK_W  block to store.
- out_valid  out  1  block_out holds the oldest stored block.
- out_ready  in  1  consumer takes block_out this cycle.
- block_out  out  BLOCK_W  oldest block (head entry).
- count  out  CNT_W  number of stored blocks, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-low. While RST=0: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1 once RST deasserts, block_out=0, full=0, empty=1. Storage array contents are don't-care (not reset).
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the rising edge.
- in_ready = !full, combinational from the count register. It never depends on out_ready, so there is no pass-through when full.
- out_valid = !empty. block_out is the head entry, read combinationally from the array (first-word fall-through). It is driven to all zeros while empty.
- Latency: a block pushed into an empty buffer at edge N appears on block_out with out_valid=1 immediately after edge N (1 cycle).
- Pointers:
  - wr_ptr advances on push; rd_ptr advances on pop.
  - Each wraps from DEPTH-1 to 0 by explicit compare, not by bit truncation, so non-power-of-two depths work.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Simultaneous push and pop are legal whenever count is between 1 and DEPTH-1.
- At full, only pop is possible. At empty, only push is possible (out_valid=0 masks pop).
- Push when full (in_ready=0) is ignored: data is not written and no pointer moves. Pop when empty is ignored likewise.
- flush=1 at an edge: pointers and count go to 0 and out_valid drops the next cycle. Any push or pop in the same cycle is discarded.
- An asynchronous reset mid-operation discards all contents and drops out_valid immediately, without waiting for a clock edge.
- block_in is sampled only on a push. It may change freely otherwise.
- There is no state machine; all control is pointer/count based. count is the only source for full, empty, in_ready and out_valid.

Decomposition:
- Shared package sha_pkg holds:
  - SHA_BLOCK_W=512 and SHA_TAIL_BLOCK_W=448 constants.
  - A function for the wrapping pointer increment.
- A single sub-module, sha_fifo_ptr, is natural: a wrapping pointer counter with parameter DEPTH and inputs CLK, RST, clr, inc. Instantiate it twice, once for wr_ptr and once for rd_ptr.
- The storage array is inline; no RAM macro is needed at these depths.

Test Plan:
- Reset: hold RST=0 with in_valid=1 -> count=0, empty=1, out_valid=0, block_out=0. After release, in_ready=1.
- Fill and drain with DEPTH=4, out_ready=0: push 4 blocks A..D (A=448'h1, D=448'h4) -> full=1, in_ready=0, count=4. A 5th push is ignored. Raising out_ready yields A, B, C, D in order, then empty=1.
- Fall-through: push 448'hDEADBEEF into an empty buffer at edge N -> out_valid=1 and block_out=448'hDEADBEEF after edge N.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2 and output order is preserved. Pointers wrap past entry 3.
- DEPTH=3, BLOCK_W=512: run 20 pushes and pops interleaved randomly against a scoreboard -> no loss or reorder, and count never exceeds 3.
- flush with count=3 and a push in the same cycle -> count=0 and empty=1 the next cycle, with the pushed block discarded. Separately, assert RST low mid-stream -> out_valid drops without a clock edge.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared constants and helpers for the SHA message-block datapath.
package sha_pkg;

    localparam int SHA_BLOCK_W      = 512;
    localparam int SHA_TAIL_BLOCK_W = 448;

    // Wraps by explicit compare so non-power-of-two depths cycle correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sha_fifo_ptr.sv
// Wrapping index counter for the block FIFO (used for both read and write sides).
module sha_fifo_ptr
    import sha_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = PTR_W'(ptr_inc(32'(ptr_q), 32'(DEPTH)));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sha_block_fifo.sv
// Multi-entry first-word-fall-through buffer for SHA message blocks, placed
// between the block/nonce generator and the SHA-256 core.
module sha_block_fifo
    import sha_pkg::*;
#(
    parameter int BLOCK_W = SHA_TAIL_BLOCK_W,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] block_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] block_out,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic [BLOCK_W-1:0] mem_q [DEPTH];

    // All handshake flags derive from count alone; no path from out_ready to in_ready.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    sha_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .CLK (CLK),
        .RST (RST),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    sha_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .CLK (CLK),
        .RST (RST),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Storage is deliberately left unreset; empty masks the head on block_out.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge CLK) begin
            if (push && !flush && (wr_ptr == PTR_W'(gi))) begin
                mem_q[gi] <= block_in;
            end
        end
    end

    assign block_out = empty ? '0 : mem_q[rd_ptr];

endmodule

// File: tb/tb_sha_block_fifo.sv
// Scoreboard bench for sha_block_fifo at DEPTH=4/448b and DEPTH=3/512b.
module tb_sha_block_fifo;

    logic         CLK;
    logic         RST;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_full, a_empty;
    logic [447:0] a_block_in, a_block_out;
    logic [2:0]   a_count;

    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_full, b_empty;
    logic [511:0] b_block_in, b_block_out;
    logic [1:0]   b_count;

    logic [447:0] q_a[$];
    logic [511:0] q_b[$];

    int check_cnt = 0;
    int pass_cnt  = 0;

    sha_block_fifo #(.BLOCK_W(448), .DEPTH(4)) u_dut_a (
        .CLK(CLK), .RST(RST), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .block_in(a_block_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .block_out(a_block_out),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    sha_block_fifo #(.BLOCK_W(512), .DEPTH(3)) u_dut_b (
        .CLK(CLK), .RST(RST), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .block_in(b_block_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .block_out(b_block_out),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of DUT A: drive, predict handshakes at the negedge, then advance past posedge.
    task automatic cycle_a(input logic fl, input logic v, input logic [447:0] d, input logic r);
        logic [447:0] exp;
        a_flush = fl; a_in_valid = v; a_block_in = d; a_out_ready = r;
        @(negedge CLK);
        check("a_count", 512'(a_count), 512'(q_a.size()));
        $display("a: flush=%0d push=%0d pop=%0d count=%0d", fl, v && a_in_ready, r && a_out_valid, a_count);
        if (fl) begin
            q_a.delete();
        end else begin
            if (r && a_out_valid) begin
                exp = (q_a.size() > 0) ? q_a.pop_front() : '0;
                check("a_pop_data", 512'(a_block_out), 512'(exp));
            end
            if (v && a_in_ready) q_a.push_back(d);
        end
        @(posedge CLK); #1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    endtask

    task automatic cycle_b(input logic v, input logic [511:0] d, input logic r);
        logic [511:0] exp;
        b_flush = 1'b0; b_in_valid = v; b_block_in = d; b_out_ready = r;
        @(negedge CLK);
        check("b_count", 512'(b_count), 512'(q_b.size()));
        if (b_count > 2'd3 || q_b.size() > 3) check("b_count_bound", 512'(b_count), 512'd3);
        $display("b: push=%0d pop=%0d count=%0d", v && b_in_ready, r && b_out_valid, b_count);
        if (r && b_out_valid) begin
            exp = (q_b.size() > 0) ? q_b.pop_front() : '0;
            check("b_pop_data", b_block_out, exp);
        end
        if (v && b_in_ready) q_b.push_back(d);
        @(posedge CLK); #1;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b1; a_block_in = 448'h1; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b1; b_block_in = 512'h7; b_out_ready = 1'b0;

        // Reset held with in_valid asserted across edges.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_count", 512'(a_count), 512'd0);
        check("rst_empty", 512'(a_empty), 512'd1);
        check("rst_full", 512'(a_full), 512'd0);
        check("rst_out_valid", 512'(a_out_valid), 512'd0);
        check("rst_block_out", 512'(a_block_out), 512'd0);
        check("rst_b_empty", 512'(b_empty), 512'd1);
        @(posedge CLK); #1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("rel_in_ready", 512'(a_in_ready), 512'd1);
        @(posedge CLK); #1;

        // Fill to full, attempt a fifth push, then drain in order.
        for (int i = 1; i <= 4; i++) cycle_a(1'b0, 1'b1, 448'(i), 1'b0);
        @(negedge CLK);
        check("fill_full", 512'(a_full), 512'd1);
        check("fill_in_ready", 512'(a_in_ready), 512'd0);
        check("fill_count", 512'(a_count), 512'd4);
        @(posedge CLK); #1;
        cycle_a(1'b0, 1'b1, 448'h5, 1'b0);
        for (int i = 0; i < 4; i++) cycle_a(1'b0, 1'b0, '0, 1'b1);
        @(negedge CLK);
        check("drain_empty", 512'(a_empty), 512'd1);
        check("drain_out_valid", 512'(a_out_valid), 512'd0);
        @(posedge CLK); #1;

        // Fall-through: visible right after the pushing edge.
        cycle_a(1'b0, 1'b1, 448'hDEADBEEF, 1'b0);
        check("fwft_valid", 512'(a_out_valid), 512'd1);
        check("fwft_data", 512'(a_block_out), 512'hDEADBEEF);

        // Steady simultaneous push/pop at count=2, wrapping both pointers.
        cycle_a(1'b0, 1'b1, 448'h100, 1'b0);
        for (int i = 0; i < 10; i++) cycle_a(1'b0, 1'b1, 448'h200 + 448'(i), 1'b1);
        check("pp_count", 512'(a_count), 512'd2);
        cycle_a(1'b0, 1'b0, '0, 1'b1);
        cycle_a(1'b0, 1'b0, '0, 1'b1);

        // Flush at count=3 with a concurrent push.
        for (int i = 0; i < 3; i++) cycle_a(1'b0, 1'b1, 448'h300 + 448'(i), 1'b0);
        cycle_a(1'b1, 1'b1, 448'h3FF, 1'b1);
        check("flush_count", 512'(a_count), 512'd0);
        check("flush_empty", 512'(a_empty), 512'd1);
        cycle_a(1'b0, 1'b1, 448'h400, 1'b0);
        cycle_a(1'b0, 1'b0, '0, 1'b1);

        // Randomised traffic on the DEPTH=3, 512-bit instance.
        for (int i = 0; i < 40; i++) begin
            cycle_b(1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) cycle_b(1'b0, '0, 1'b1);
        check("b_final_empty", 512'(b_empty), 512'd1);

        // Asynchronous reset mid-stream.
        cycle_a(1'b0, 1'b1, 448'h500, 1'b0);
        cycle_a(1'b0, 1'b1, 448'h501, 1'b0);
        check("arst_pre_valid", 512'(a_out_valid), 512'd1);
        #2 RST = 1'b0;
        #1;
        check("arst_out_valid", 512'(a_out_valid), 512'd0);
        check("arst_count", 512'(a_count), 512'd0);
        check("arst_block_out", 512'(a_block_out), 512'd0);
        q_a.delete();
        q_b.delete();
        @(posedge CLK); #1;
        RST = 1'b1;
        cycle_a(1'b0, 1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
